memory_read_arbiter: RTL and testbench

- Shares the single registered read port of the 16-entry, 8-bit ROM (`Memory`, 1-cycle read latency) among NUM_REQ requesters.
- Round-robin grant, at most one read per cycle, fully pipelined (back-to-back reads at one per cycle).
- Per-requester response handshake with a 1-entry hold buffer absorbs response backpressure.
- Sits between requester blocks (fetch, table lookup, etc.) and the `Memory` instance.

---
 rtl/memory_read_arbiter_pkg.sv | 12 +
 rtl/memory_read_arbiter_rr_arbiter.sv | 36 +++
 rtl/memory_read_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_read_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_read_arbiter_pkg.sv
// Shared constants and types for the memory read arbiter.
// Default sizes match the 16-entry, 8-bit ROM behind the arbiter.
package memory_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int RD_LATENCY     = 1;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/memory_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!any_grant && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                    any_grant  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memory_read_arbiter.sv
// Shares one registered ROM read port among NUM_REQ requesters, round-robin,
// one read per cycle, with a 1-entry hold buffer for response backpressure.
module memory_read_arbiter
    import memory_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr,
    input  logic [DATA_WIDTH-1:0]         mem_read_data
);

    localparam int ID_W = $clog2(NUM_REQ);

    // run_q keeps grants off for the first cycle after reset is released.
    logic                  run_q,        run_d;
    logic [ID_W-1:0]       rr_ptr_q,     rr_ptr_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [ID_W-1:0]       pipe_id_q,    pipe_id_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [ID_W-1:0]       hold_id_q,    hold_id_d;
    logic [DATA_WIDTH-1:0] hold_data_q,  hold_data_d;

    logic                  pipe_stall;
    logic                  grant_en;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  any_grant;

    assign pipe_stall = pipe_valid_q && !rsp_ready[pipe_id_q];
    assign grant_en   = !reset && run_q && !hold_valid_q && !pipe_stall;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (grant_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        mem_read_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mem_read_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Held data takes precedence; pipe and hold are never valid together.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (!reset) begin
            if (hold_valid_q) begin
                rsp_valid[hold_id_q] = 1'b1;
                rsp_data             = hold_data_q;
            end else if (pipe_valid_q) begin
                rsp_valid[pipe_id_q] = 1'b1;
                rsp_data             = mem_read_data;
            end
        end
    end

    always_comb begin
        run_d        = 1'b1;
        rr_ptr_d     = rr_ptr_q;
        pipe_valid_d = any_grant;
        pipe_id_d    = any_grant ? grant_id : pipe_id_q;
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        hold_data_d  = hold_data_q;

        if (any_grant) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end

        if (hold_valid_q) begin
            if (rsp_ready[hold_id_q]) begin
                hold_valid_d = 1'b0;
            end
        end else if (pipe_stall) begin
            hold_valid_d = 1'b1;
            hold_id_d    = pipe_id_q;
            hold_data_d  = mem_read_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q        <= 1'b0;
            rr_ptr_q     <= '0;
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            run_q        <= run_d;
            rr_ptr_q     <= rr_ptr_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter with a behavioural 1-cycle ROM.
module tb_memory_read_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_ready;
    logic [15:0] mem_read_addr;
    logic [7:0]  mem_read_data;

    logic [7:0]  rom [16];
    int checks;
    int errors;

    memory_read_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_read_data <= (mem_read_addr < 16'd16) ? rom[mem_read_addr[3:0]] : 8'h00;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [15:0] a);
        req_addr[i*16 +: 16] = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        set_addr(0, 16'd0); set_addr(1, 16'd2); set_addr(2, 16'd13); set_addr(3, 16'd15);
        rsp_ready = 4'hF;
        tick(); tick();
        @(negedge clock);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
        checks++; if (mem_read_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", mem_read_addr); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL post_reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL post_reset_rsp_valid got %b exp 0000", rsp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [15:0] addrs [4];
        logic [7:0]  datas [4];
        addrs[0] = 16'd0; addrs[1] = 16'd2; addrs[2] = 16'd13; addrs[3] = 16'd15;
        datas[0] = 8'h05; datas[1] = 8'h08; datas[2] = 8'h16; datas[3] = 8'h1F;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = 4'h0;
            @(negedge clock);
            if (k < 5) begin
                checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
                checks++; if (mem_read_addr !== addrs[k % 4]) begin errors++; $display("FAIL rr_addr k=%0d got %h exp %h", k, mem_read_addr, addrs[k % 4]); end
            end else begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_grant got %b exp 0000", req_ready); end
            end
            if (k > 0) begin
                checks++; if (rsp_valid !== (4'b0001 << ((k - 1) % 4))) begin errors++; $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, 4'b0001 << ((k - 1) % 4)); end
                checks++; if (rsp_data !== datas[(k - 1) % 4]) begin errors++; $display("FAIL rr_rsp_data k=%0d got %h exp %h", k, rsp_data, datas[(k - 1) % 4]); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_first_rsp got %b exp 0000", rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        set_addr(0, 16'h0001);
        @(negedge clock);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", req_ready); end
        checks++; if (mem_read_addr !== 16'h0001) begin errors++; $display("FAIL single_addr got %h exp 0001", mem_read_addr); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got %b exp 0000", rsp_valid); end
        tick();
        req_valid = 4'b0000;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
        checks++; if (rsp_data !== 8'h0A) begin errors++; $display("FAIL single_rsp_data got %h exp 0a", rsp_data); end
        tick();
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        set_addr(1, 16'd10);
        set_addr(3, 16'd2);
        rsp_ready = 4'hF;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
        checks++; if (mem_read_addr !== 16'd10) begin errors++; $display("FAIL bp_addr got %h exp 000a", mem_read_addr); end
        tick();
        req_valid = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            rsp_ready = (c == 4) ? 4'b1111 : 4'b1101;
            @(negedge clock);
            checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_rsp_valid c=%0d got %b exp 0010", c, rsp_valid); end
            checks++; if (rsp_data !== 8'h14) begin errors++; $display("FAIL bp_rsp_data c=%0d got %h exp 14", c, rsp_data); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant c=%0d got %b exp 0000", c, req_ready); end
            tick();
        end
        @(negedge clock);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume_grant got %b exp 1000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_bubble_rsp got %b exp 0000", rsp_valid); end
        tick();
        req_valid = 4'b0000;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL bp_resume_rsp got %b exp 1000", rsp_valid); end
        checks++; if (rsp_data !== 8'h08) begin errors++; $display("FAIL bp_resume_data got %h exp 08", rsp_data); end
        tick();
    endtask

    task automatic test_overlap();
        req_valid = 4'b0100;
        set_addr(2, 16'd4);
        @(negedge clock);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ov_grant0 got %b exp 0100", req_ready); end
        checks++; if (mem_read_addr !== 16'd4) begin errors++; $display("FAIL ov_addr0 got %h exp 0004", mem_read_addr); end
        tick();
        set_addr(2, 16'd5);
        @(negedge clock);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ov_grant1 got %b exp 0100", req_ready); end
        checks++; if (mem_read_addr !== 16'd5) begin errors++; $display("FAIL ov_addr1 got %h exp 0005", mem_read_addr); end
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL ov_rsp0_valid got %b exp 0100", rsp_valid); end
        checks++; if (rsp_data !== 8'h02) begin errors++; $display("FAIL ov_rsp0_data got %h exp 02", rsp_data); end
        tick();
        req_valid = 4'b0000;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL ov_rsp1_valid got %b exp 0100", rsp_valid); end
        checks++; if (rsp_data !== 8'h01) begin errors++; $display("FAIL ov_rsp1_data got %h exp 01", rsp_data); end
        tick();
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b1000;
        set_addr(3, 16'd15);
        set_addr(0, 16'd0);
        @(negedge clock);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_grant got %b exp 1000", req_ready); end
        tick();
        reset = 1'b1;
        req_valid = 4'b1001;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_t1 got %b exp 0000", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_grant_t1 got %b exp 0000", req_ready); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_t2 got %b exp 0000", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_grant_t2 got %b exp 0000", req_ready); end
        tick();
        @(negedge clock);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant got %b exp 0001", req_ready); end
        checks++; if (mem_read_addr !== 16'd0) begin errors++; $display("FAIL rm_first_addr got %h exp 0000", mem_read_addr); end
        tick();
        req_valid = 4'b0000;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_rsp got %b exp 0001", rsp_valid); end
        checks++; if (rsp_data !== 8'h05) begin errors++; $display("FAIL rm_rsp_data got %h exp 05", rsp_data); end
        tick();
    endtask

    task automatic test_idle();
        req_valid = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_grant c=%0d got %b exp 0000", c, req_ready); end
            checks++; if (mem_read_addr !== 16'd0) begin errors++; $display("FAIL idle_addr c=%0d got %h exp 0000", c, mem_read_addr); end
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_rsp c=%0d got %b exp 0000", c, rsp_valid); end
            tick();
        end
        req_valid = 4'b0011;
        set_addr(0, 16'd1);
        set_addr(1, 16'd5);
        @(negedge clock);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL idle_ptr_grant got %b exp 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL idle_ptr_rsp got %b exp 0010", rsp_valid); end
        checks++; if (rsp_data !== 8'h01) begin errors++; $display("FAIL idle_ptr_data got %h exp 01", rsp_data); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rom[0]  = 8'h05; rom[1]  = 8'h0A; rom[2]  = 8'h08; rom[3]  = 8'h33;
        rom[4]  = 8'h02; rom[5]  = 8'h01; rom[6]  = 8'h66; rom[7]  = 8'h77;
        rom[8]  = 8'h88; rom[9]  = 8'h99; rom[10] = 8'h14; rom[11] = 8'hBB;
        rom[12] = 8'hCC; rom[13] = 8'h16; rom[14] = 8'hEE; rom[15] = 8'h1F;
        reset     = 1'b1;
        req_valid = 4'h0;
        req_addr  = '0;
        rsp_ready = 4'hF;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_overlap();
        test_reset_midflight();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
